// File: rtl/bk_seq.sv
// Save-file sector sequencer: streams one slot's worth of 512-byte sectors
// between the core's backup RAM and hps_io, one sd_rd/sd_wr handshake per sector.
module bk_seq #(
    parameter int SLOT_BITS = 2,
    parameter int SECT_BITS = 6,
    parameter int TMO_W     = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 bk_ena,
    input  logic                 bk_load,
    input  logic                 bk_save,
    input  logic [SLOT_BITS-1:0] slot,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic                 bk_loading,
    output logic                 bk_busy,
    output logic                 bk_done,
    output logic                 bk_err
);
    localparam int PAD = 32 - SLOT_BITS - SECT_BITS;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t           state;
    logic             old_load, old_save, old_ack;
    logic             dir_rd;
    logic [TMO_W-1:0] tmo;

    logic start_load, start_save, ack_rise, ack_fall, last_sect, abort;

    assign start_load = bk_load & bk_ena & ~old_load;
    assign start_save = bk_save & bk_ena & ~old_save;
    assign ack_rise   = sd_ack & ~old_ack;
    assign ack_fall   = ~sd_ack & old_ack;
    assign last_sect  = &sd_lba[SECT_BITS-1:0];
    // Abort outranks any ack edge seen in the same cycle.
    assign abort      = (state != IDLE) & (~bk_ena | (&tmo));
    assign bk_busy    = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sd_lba     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            bk_done    <= 1'b0;
            bk_err     <= 1'b0;
            old_load   <= 1'b0;
            old_save   <= 1'b0;
            old_ack    <= 1'b0;
            dir_rd     <= 1'b0;
            tmo        <= '0;
        end else begin
            old_load <= bk_load & bk_ena;
            old_save <= bk_save & bk_ena;
            old_ack  <= sd_ack;
            bk_done  <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                sd_rd      <= 1'b0;
                sd_wr      <= 1'b0;
                bk_loading <= 1'b0;
                bk_err     <= 1'b1;
                tmo        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_load | start_save) begin
                            state      <= REQ;
                            sd_lba     <= {{PAD{1'b0}}, slot, {SECT_BITS{1'b0}}};
                            bk_err     <= 1'b0;
                            dir_rd     <= start_load;
                            sd_rd      <= start_load;
                            sd_wr      <= ~start_load;
                            bk_loading <= start_load;
                            tmo        <= '0;
                        end
                    end
                    REQ: begin
                        if (ack_rise) begin
                            sd_rd <= 1'b0;
                            sd_wr <= 1'b0;
                            state <= XFER;
                            tmo   <= '0;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    XFER: begin
                        if (ack_fall) begin
                            tmo <= '0;
                            if (last_sect) begin
                                state      <= IDLE;
                                bk_loading <= 1'b0;
                                bk_done    <= 1'b1;
                            end else begin
                                // Only the sector field advances; the slot field is fixed.
                                sd_lba[SECT_BITS-1:0] <= sd_lba[SECT_BITS-1:0] + SECT_BITS'(1);
                                sd_rd <= dir_rd;
                                sd_wr <= ~dir_rd;
                                state <= REQ;
                            end
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bk_seq.sv
// Directed bench for bk_seq: full-slot loads/saves from a vector table, then
// timeout, bk_ena-drop and async-reset corner sequences.
module tb_bk_seq;
    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        bk_ena  = 1'b1;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic [1:0]  slot    = 2'd0;
    logic        sd_ack  = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_loading, bk_busy, bk_done, bk_err;

    int n_chk = 0;
    int n_err = 0;

    bk_seq #(.SLOT_BITS(2), .SECT_BITS(6), .TMO_W(4)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .bk_load(bk_load),
        .bk_save(bk_save), .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .bk_loading(bk_loading),
        .bk_busy(bk_busy), .bk_done(bk_done), .bk_err(bk_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] slot;
        logic       ld;
        logic       sv;
        int         exp_rd;
        int         exp_wr;
        int         exp_first;
        int         exp_last;
        logic       exp_loading;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One sector with the ack model; called at a negedge with sd_rd/sd_wr visible.
    task automatic step_sector();
        int w = 0;
        while (!(sd_rd || sd_wr) && w < 20) begin
            @(negedge clk_sys);
            w++;
        end
        chk("step_req_seen", int'(sd_rd || sd_wr), 1);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        sd_ack = 1'b0;
        @(negedge clk_sys);
    endtask

    // Whole operation with a 1-cycle-high ack per sector; called at a negedge.
    task automatic run_op(input logic [1:0] s, input logic ld, input logic sv,
                          output int nrd, output int nwr, output int first,
                          output int last, output int seq_bad, output int both,
                          output int ndone, output int nbusy, output int nload,
                          output int hung);
        int cyc = 0;
        int prev = -1;
        nrd = 0; nwr = 0; first = -1; last = -1; seq_bad = 0; both = 0;
        ndone = 0; nbusy = 0; nload = 0; hung = 0;
        slot = s; bk_load = ld; bk_save = sv;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (sd_rd && sd_wr) both++;
            if (bk_done) ndone++;
            if (bk_busy) begin
                nbusy++;
                if (bk_loading) nload++;
            end
            if (sd_ack) sd_ack = 1'b0;
            else if (sd_rd || sd_wr) begin
                if (sd_rd) nrd++;
                if (sd_wr) nwr++;
                if (first < 0) first = int'(sd_lba);
                else if (int'(sd_lba) != prev + 1) seq_bad++;
                prev = int'(sd_lba);
                last = prev;
                sd_ack = 1'b1;
            end
            if (!bk_busy && cyc > 1) break;
            if (cyc >= 1000) begin
                hung = 1;
                break;
            end
        end
        sd_ack = 1'b0;
    endtask

    initial begin
        int nrd, nwr, first, last, seq_bad, both, ndone, nbusy, nload, hung;
        int nb, nd, w;

        vecs[0] = '{slot: 2'd2, ld: 1'b1, sv: 1'b0, exp_rd: 64, exp_wr: 0,  exp_first: 128, exp_last: 191, exp_loading: 1'b1};
        vecs[1] = '{slot: 2'd3, ld: 1'b0, sv: 1'b1, exp_rd: 0,  exp_wr: 64, exp_first: 192, exp_last: 255, exp_loading: 1'b0};
        vecs[2] = '{slot: 2'd1, ld: 1'b1, sv: 1'b1, exp_rd: 64, exp_wr: 0,  exp_first: 64,  exp_last: 127, exp_loading: 1'b1};
        vecs[3] = '{slot: 2'd0, ld: 1'b0, sv: 1'b1, exp_rd: 0,  exp_wr: 64, exp_first: 0,   exp_last: 63,  exp_loading: 1'b0};

        // Reset state
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_busy", bk_busy, 0);
        chk("rst_rd", sd_rd, 0);
        chk("rst_wr", sd_wr, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_loading", bk_loading, 0);
        chk("rst_done", bk_done, 0);
        chk("rst_err", bk_err, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].slot, vecs[i].ld, vecs[i].sv, nrd, nwr, first, last,
                   seq_bad, both, ndone, nbusy, nload, hung);
            chk($sformatf("v%0d_hung", i), hung, 0);
            chk($sformatf("v%0d_rd_pulses", i), nrd, vecs[i].exp_rd);
            chk($sformatf("v%0d_wr_pulses", i), nwr, vecs[i].exp_wr);
            chk($sformatf("v%0d_first_lba", i), first, vecs[i].exp_first);
            chk($sformatf("v%0d_last_lba", i), last, vecs[i].exp_last);
            chk($sformatf("v%0d_lba_seq", i), seq_bad, 0);
            chk($sformatf("v%0d_rd_wr_both", i), both, 0);
            chk($sformatf("v%0d_done_cnt", i), ndone, 1);
            chk($sformatf("v%0d_busy_cycles", i), nbusy, 128);
            chk($sformatf("v%0d_loading_cycles", i), nload, vecs[i].exp_loading ? 128 : 0);
            chk($sformatf("v%0d_err", i), bk_err, 0);
            // Request still held: must not retrigger, and done must not repeat
            nb = 0; nd = 0;
            repeat (4) begin
                @(negedge clk_sys);
                if (bk_busy) nb++;
                if (bk_done) nd++;
            end
            chk($sformatf("v%0d_no_retrigger", i), nb, 0);
            chk($sformatf("v%0d_done_once", i), nd, 0);
            bk_load = 1'b0; bk_save = 1'b0;
            @(negedge clk_sys);
        end

        // Ack never arrives: REQ phase times out
        slot = 2'd1; bk_load = 1'b1;
        nb = 0; nd = 0; w = 0;
        do begin
            @(negedge clk_sys);
            w++;
            if (bk_busy) nb++;
            if (bk_done) nd++;
        end while ((bk_busy || w < 2) && w < 60);
        chk("tmo_busy_len_15_16", int'(nb >= 15 && nb <= 16), 1);
        chk("tmo_err", bk_err, 1);
        chk("tmo_busy", bk_busy, 0);
        chk("tmo_rd", sd_rd, 0);
        chk("tmo_loading", bk_loading, 0);
        chk("tmo_no_done", nd, 0);
        bk_load = 1'b0; bk_save = 1'b1;
        @(negedge clk_sys);
        chk("save_clears_err", bk_err, 0);
        chk("save_wr", sd_wr, 1);
        chk("save_rd", sd_rd, 0);
        chk("save_lba", sd_lba, 64);
        bk_save = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("tmo2_err", bk_err, 1);
        chk("tmo2_busy", bk_busy, 0);

        // bk_ena drop at sector 5 of a load, then re-qualified start
        slot = 2'd2; bk_load = 1'b1;
        @(negedge clk_sys);
        chk("ena_start_lba", sd_lba, 128);
        chk("ena_start_err", bk_err, 0);
        repeat (5) step_sector();
        chk("ena_sect5_lba", sd_lba, 133);
        chk("ena_sect5_rd", sd_rd, 1);
        bk_ena = 1'b0;
        @(negedge clk_sys);
        chk("ena_abort_busy", bk_busy, 0);
        chk("ena_abort_err", bk_err, 1);
        chk("ena_abort_loading", bk_loading, 0);
        chk("ena_abort_rd", sd_rd, 0);
        bk_ena = 1'b1;
        @(negedge clk_sys);
        chk("ena_restart_busy", bk_busy, 1);
        chk("ena_restart_rd", sd_rd, 1);
        chk("ena_restart_lba", sd_lba, 128);
        chk("ena_restart_loading", bk_loading, 1);
        chk("ena_restart_err", bk_err, 0);

        // Async reset during XFER, between clock edges
        repeat (3) step_sector();
        chk("rst_pre_lba", sd_lba, 131);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        chk("rst_pre_xfer_busy", bk_busy, 1);
        chk("rst_pre_xfer_rd", sd_rd, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", bk_busy, 0);
        chk("arst_rd", sd_rd, 0);
        chk("arst_wr", sd_wr, 0);
        chk("arst_lba", sd_lba, 0);
        chk("arst_loading", bk_loading, 0);
        sd_ack = 1'b0; bk_load = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        run_op(2'd2, 1'b1, 1'b0, nrd, nwr, first, last, seq_bad, both,
               ndone, nbusy, nload, hung);
        chk("post_rst_hung", hung, 0);
        chk("post_rst_first_lba", first, 128);
        chk("post_rst_last_lba", last, 191);
        chk("post_rst_rd_pulses", nrd, 64);
        chk("post_rst_wr_pulses", nwr, 0);
        chk("post_rst_done", ndone, 1);
        bk_load = 1'b0;
        @(negedge clk_sys);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bk_seq.md
BK_SEQ -- requirements
Module: bk_seq

Interface
REQ-001 SHALL have parameter SLOT_BITS, default 2, meaning the save-slot select width (2^SLOT_BITS slots).
REQ-002 SHALL have parameter SECT_BITS, default 6, meaning sectors per slot = 2^SECT_BITS (512 B each).
REQ-003 SHALL have parameter TMO_W, default 24, meaning the width of the per-phase ack timeout counter.
REQ-004 SHALL have port clk_sys, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port bk_ena, input, 1, save file mounted and writable.
REQ-007 SHALL have port bk_load, input, 1, load request level; a qualified rising edge starts a load.
REQ-008 SHALL have port bk_save, input, 1, save request level; a qualified rising edge starts a save.
REQ-009 SHALL have port slot, input, SLOT_BITS, slot select, sampled at start.
REQ-010 SHALL have port sd_lba, output, 32, sector address to hps_io.
REQ-011 SHALL have ports sd_rd and sd_wr, output, 1 each, sector read/write requests.
REQ-012 SHALL have port sd_ack, input, 1, hps_io transfer acknowledge (high during one sector transfer).
REQ-013 SHALL have port bk_loading, output, 1, high during a load (holds the core in reset).
REQ-014 SHALL have port bk_busy, output, 1, high while not IDLE.
REQ-015 SHALL have port bk_done, output, 1, one-cycle pulse on successful completion.
REQ-016 SHALL have port bk_err, output, 1, sticky error flag.

Function
REQ-017 SHALL register old_load <= bk_load & bk_ena and old_save <= bk_save & bk_ena every cycle, in all states.
REQ-018 SHALL define start_load = bk_load & bk_ena & ~old_load and start_save = bk_save & bk_ena & ~old_save.
REQ-019 SHALL implement states IDLE, REQ, XFER; bk_busy = (state != IDLE).
REQ-020 In IDLE, on start_load or start_save: SHALL go to REQ, latch slot, set sd_lba = zero-extended {slot, SECT_BITS'b0}, clear bk_err; sd_rd/sd_wr visible the next cycle.
REQ-021 When start_load and start_save coincide, load SHALL win: sd_rd=1, sd_wr=0, bk_loading=1.
REQ-022 Save SHALL set sd_wr=1, sd_rd=0, bk_loading=0.
REQ-023 In REQ, on sd_ack rising (registered old_ack low, sd_ack high): SHALL clear sd_rd and sd_wr and go to XFER.
REQ-024 In XFER, on sd_ack falling with sd_lba[SECT_BITS-1:0] all ones: SHALL go to IDLE, clear bk_loading, pulse bk_done.
REQ-025 In XFER, on sd_ack falling otherwise: SHALL increment sd_lba by 1, reassert the latched direction (sd_rd or sd_wr), and return to REQ.
REQ-026 sd_lba bits above SLOT_BITS+SECT_BITS SHALL stay 0; the slot field SHALL never change mid-operation.
REQ-027 Start edges in REQ/XFER SHALL be ignored; old_load/old_save still track, so a request held high does not retrigger after completion.
REQ-028 SHALL clear the timeout counter on every entry to REQ or XFER and increment it each cycle in those states.
REQ-029 Counter reaching all ones (2^TMO_W-1 cycles in one phase) SHALL abort: go to IDLE, clear sd_rd/sd_wr/bk_loading, set bk_err, no bk_done.
REQ-030 bk_ena low while busy SHALL abort the same way as REQ-029.
REQ-031 Abort and a completing ack edge in the same cycle SHALL resolve as abort.
REQ-032 bk_err SHALL stay set until the next accepted start or reset.
REQ-033 sd_rd and sd_wr SHALL never both be 1.

Reset
REQ-034 reset SHALL asynchronously force state=IDLE, sd_lba=0, sd_rd=0, sd_wr=0, bk_loading=0, bk_done=0, bk_err=0, old_load=0, old_save=0, old_ack=0, and timeout counter=0.
REQ-035 Reset mid-transfer SHALL drop all requests immediately; the next request after release SHALL start from sector 0 of its slot.

Verification
REQ-036 Load, slot=2, defaults, model ack 1 high per sector -> sd_rd pulses 64 times, sd_lba 128..191, bk_loading high throughout, one bk_done after the ack fall at 191.
REQ-037 Save, slot=3 -> sd_wr only, sd_lba 192..255, bk_loading 0, bk_done once, sd_rd never 1.
REQ-038 bk_load and bk_save rise same cycle -> load performed, sd_wr stays 0.
REQ-039 TMO_W=4, ack never arrives -> bk_err=1 and bk_busy=0 after 15 cycles in REQ, sd_rd=0; a new save clears bk_err.
REQ-040 bk_ena dropped at sector 5 of a load -> immediate IDLE, bk_err=1, bk_loading=0; bk_load held high then bk_ena restored -> new load starts (qualified edge).
REQ-041 Async reset asserted during XFER -> outputs go 0 without a clock edge; a subsequent load starts at lba {slot,000000}.
